// File: rtl/stopwatch_input_ctrl.sv
// Input conditioning and timebase for the stopwatch counter core: button
// synchronisation/debounce, pause toggle, switch registration and count enables.
module stopwatch_input_ctrl #(
  parameter int SAMPLE_DIV = 250000,
  parameter int DEB_COUNT  = 4,
  parameter int HALF_DIV   = 50000000
) (
  input  logic       src_clk,
  input  logic       src_rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic [2:0] sw,
  output logic       pause,
  output logic       clr_pulse,
  output logic       clr_hold,
  output logic       count_tick,
  output logic [1:0] mode,
  output logic       adj_min,
  output logic       blink
);

  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(DEB_COUNT);
  localparam int HW = $clog2(HALF_DIV);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_COUNT - 1);
  localparam logic [HW-1:0] HALF_LAST   = HW'(HALF_DIV - 1);

  // Bit map: [0] pause button, [1] clear button, [4:2] switches
  logic [4:0] raw_in;
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  assign raw_in = {sw, btn_clr, btn_pause};

  always_ff @(posedge src_clk or negedge src_rst) begin
    if (!src_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  logic [SW-1:0] samp_cnt_q;
  logic [SW-1:0] samp_cnt_d;
  logic          sample_tick;

  assign sample_tick = (samp_cnt_q == SAMPLE_LAST);
  assign samp_cnt_d  = sample_tick ? '0 : samp_cnt_q + 1'b1;

  always_ff @(posedge src_clk or negedge src_rst) begin
    if (!src_rst) begin
      samp_cnt_q <= '0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
    end
  end

  logic [1:0] stable_lvl;
  logic [1:0] stable_rise;

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // A matching sample clears the count, so any bounce restarts qualification
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (sample_tick) begin
        if (sync2_q[gi] != lvl_q) begin
          if (cnt_q == DEB_LAST) begin
            lvl_d = sync2_q[gi];
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
    end

    always_ff @(posedge src_clk or negedge src_rst) begin
      if (!src_rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign stable_lvl[gi]  = lvl_q;
    assign stable_rise[gi] = lvl_d & ~lvl_q;
  end

  logic pause_q;
  logic pause_d;
  logic clr_press_q;

  // Press effects are registered alongside the level so they line up in time
  assign pause_d = pause_q ^ stable_rise[0];

  always_ff @(posedge src_clk or negedge src_rst) begin
    if (!src_rst) begin
      pause_q     <= 1'b0;
      clr_press_q <= 1'b0;
    end else begin
      pause_q     <= pause_d;
      clr_press_q <= stable_rise[1];
    end
  end

  logic [HW-1:0] half_cnt_q;
  logic [HW-1:0] half_cnt_d;
  logic          phase_q;
  logic          phase_d;
  logic          half_tick;
  logic          count_tick_q;
  logic          count_tick_d;

  assign half_tick = (half_cnt_q == HALF_LAST);

  // Holding the timebase during clear realigns the first tick after release
  always_comb begin
    half_cnt_d = half_tick ? '0 : half_cnt_q + 1'b1;
    phase_d    = phase_q ^ half_tick;
    if (stable_lvl[1]) begin
      half_cnt_d = '0;
      phase_d    = 1'b0;
    end
  end

  assign count_tick_d = half_tick & ((sync2_q[3:2] == 2'b01) | phase_q)
                      & ~pause_q & ~stable_lvl[1];

  always_ff @(posedge src_clk or negedge src_rst) begin
    if (!src_rst) begin
      half_cnt_q   <= '0;
      phase_q      <= 1'b0;
      count_tick_q <= 1'b0;
    end else begin
      half_cnt_q   <= half_cnt_d;
      phase_q      <= phase_d;
      count_tick_q <= count_tick_d;
    end
  end

  assign pause      = pause_q;
  assign clr_pulse  = clr_press_q;
  assign clr_hold   = stable_lvl[1];
  assign count_tick = count_tick_q;
  assign mode       = sync2_q[3:2];
  assign adj_min    = sync2_q[4];
  assign blink      = phase_q;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Self-checking bench for stopwatch_input_ctrl with small divider values so
// debounce, rates and clear realignment can be observed cycle-exactly.
module tb_stopwatch_input_ctrl;

  localparam int SAMPLE_DIV = 4;
  localparam int DEB_COUNT  = 3;
  localparam int HALF_DIV   = 10;

  logic       src_clk = 1'b0;
  logic       src_rst = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clr = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       pause, clr_pulse, clr_hold, count_tick, adj_min, blink;
  logic [1:0] mode;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];

  always #5 src_clk = ~src_clk;

  stopwatch_input_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .DEB_COUNT (DEB_COUNT),
    .HALF_DIV  (HALF_DIV)
  ) dut (
    .src_clk   (src_clk),
    .src_rst   (src_rst),
    .btn_pause (btn_pause),
    .btn_clr   (btn_clr),
    .sw        (sw),
    .pause     (pause),
    .clr_pulse (clr_pulse),
    .clr_hold  (clr_hold),
    .count_tick(count_tick),
    .mode      (mode),
    .adj_min   (adj_min),
    .blink     (blink)
  );

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return pause;
      1:       return clr_pulse;
      2:       return clr_hold;
      3:       return count_tick;
      4:       return blink;
      default: return 1'bx;
    endcase
  endfunction

  // Rising edges until the selected output equals val (sampled 1 after edge); -1 on timeout
  task automatic wait_sig(input int sel, input logic val, input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge src_clk); #1;
      if (sig_val(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] outs;
    @(negedge src_clk);
    src_rst   = 1'b0;
    btn_pause = 1'($urandom);
    btn_clr   = 1'($urandom);
    sw        = 3'($urandom);
    repeat (3) @(posedge src_clk);
    #1;
    outs = {pause, clr_pulse, clr_hold, count_tick, mode, adj_min, blink};
    tests_run++;
    if (outs !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_during: outputs=%b required=00000000", outs);
    end
    @(negedge src_clk);
    src_rst = 1'b1;
    @(posedge src_clk); #1;
    outs = {pause, clr_pulse, clr_hold, count_tick, mode, adj_min, blink};
    tests_run++;
    if (outs !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_first_cycle: outputs=%b required=00000000", outs);
    end
    @(negedge src_clk);
    btn_pause = 1'b0;
    btn_clr   = 1'b0;
    sw        = 3'b000;
    repeat (30) @(posedge src_clk);
    #1;
    tests_run++;
    if (pause !== 1'b0 || clr_hold !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_settle: pause=%b clr_hold=%b required 0 0", pause, clr_hold);
    end
  endtask

  task automatic test_debounce;
    int n, exp, glitches;
    @(negedge src_clk);
    btn_pause = 1'b1;
    exp_q.push_back(1);
    wait_sig(0, 1'b1, 30, n);
    tests_run++;
    if (n < 11 || n > 14) begin
      tests_failed++;
      $display("FAIL pause_rise_latency: cycles=%0d required 11..14", n);
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (int'(pause) != exp) begin
      tests_failed++;
      $display("FAIL pause_after_press: pause=%b required=%0d", pause, exp);
    end
    glitches = 0;
    repeat (30) begin
      @(posedge src_clk); #1;
      if (pause !== 1'b1) glitches++;
    end
    tests_run++;
    if (glitches != 0) begin
      tests_failed++;
      $display("FAIL pause_single_rise: deviations=%0d required=0", glitches);
    end
    @(negedge src_clk);
    btn_pause = 1'b0;
    repeat (25) @(posedge src_clk);
    #1;
    tests_run++;
    if (pause !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_release_no_effect: pause=%b required=1", pause);
    end
    @(negedge src_clk);
    btn_pause = 1'b1;
    exp_q.push_back(0);
    wait_sig(0, 1'b0, 30, n);
    tests_run++;
    if (n < 11 || n > 14) begin
      tests_failed++;
      $display("FAIL pause_fall_latency: cycles=%0d required 11..14", n);
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (int'(pause) != exp) begin
      tests_failed++;
      $display("FAIL pause_second_press: pause=%b required=%0d", pause, exp);
    end
    @(negedge src_clk);
    btn_pause = 1'b0;
    repeat (25) @(posedge src_clk);
  endtask

  task automatic test_bounce;
    int changes, exp;
    changes = 0;
    exp_q.push_back(0);
    for (int i = 0; i < 70; i++) begin
      @(negedge src_clk);
      if (i < 40 && (i % 4) == 0) btn_pause = ~btn_pause;
      @(posedge src_clk); #1;
      if (pause !== 1'b0) changes++;
    end
    tests_run++;
    if (changes != 0) begin
      tests_failed++;
      $display("FAIL bounce_no_edge: cycles_with_pause_high=%0d required=0", changes);
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (int'(pause) != exp) begin
      tests_failed++;
      $display("FAIL bounce_final_pause: pause=%b required=%0d", pause, exp);
    end
  endtask

  task automatic test_run_rate;
    int n, exp;
    logic b;
    wait_sig(3, 1'b1, 40, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL run_first_tick: timeout cycles=%0d required a tick within 40", n);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(2 * HALF_DIV);
      wait_sig(3, 1'b1, 40, n);
      exp = exp_q.pop_front();
      tests_run++;
      if (n != exp) begin
        tests_failed++;
        $display("FAIL run_rate_%0d: interval=%0d required=%0d", k, n, exp);
      end
    end
    @(negedge src_clk);
    sw = 3'b101;
    repeat (3) @(posedge src_clk);
    #1;
    tests_run++;
    if (mode !== 2'b01 || adj_min !== 1'b1) begin
      tests_failed++;
      $display("FAIL switch_regs: mode=%b adj_min=%b required 01 1", mode, adj_min);
    end
    wait_sig(3, 1'b1, 40, n);
    wait_sig(3, 1'b1, 40, n);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(HALF_DIV);
      wait_sig(3, 1'b1, 40, n);
      exp = exp_q.pop_front();
      tests_run++;
      if (n != exp) begin
        tests_failed++;
        $display("FAIL adjust_rate_%0d: interval=%0d required=%0d", k, n, exp);
      end
    end
    b = blink;
    wait_sig(4, ~b, 30, n);
    for (int k = 0; k < 2; k++) begin
      b = blink;
      exp_q.push_back(HALF_DIV);
      wait_sig(4, ~b, 30, n);
      exp = exp_q.pop_front();
      tests_run++;
      if (n != exp) begin
        tests_failed++;
        $display("FAIL blink_period_%0d: interval=%0d required=%0d", k, n, exp);
      end
    end
    @(negedge src_clk);
    sw = 3'b000;
    repeat (4) @(posedge src_clk);
  endtask

  task automatic test_pause_clear;
    int n, exp, ticks, extra;
    @(negedge src_clk);
    btn_pause = 1'b1;
    wait_sig(0, 1'b1, 30, n);
    @(negedge src_clk);
    btn_pause = 1'b0;
    ticks = 0;
    exp_q.push_back(0);
    repeat (100) begin
      @(posedge src_clk); #1;
      if (count_tick === 1'b1) ticks++;
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (ticks != exp || pause !== 1'b1) begin
      tests_failed++;
      $display("FAIL paused_no_tick: ticks=%0d pause=%b required ticks=%0d pause=1", ticks, pause, exp);
    end
    @(negedge src_clk);
    btn_clr = 1'b1;
    wait_sig(1, 1'b1, 30, n);
    tests_run++;
    if (n < 11 || n > 14 || pause !== 1'b1 || clr_hold !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_press: cycles=%0d pause=%b clr_hold=%b required 11..14 1 1", n, pause, clr_hold);
    end
    extra = 0;
    repeat (20) begin
      @(posedge src_clk); #1;
      if (clr_pulse === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL clr_pulse_width: extra_high_cycles=%0d required=0", extra);
    end
    @(negedge src_clk);
    btn_pause = 1'b1;
    wait_sig(0, 1'b0, 30, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL unpause_under_clear: pause=%b required=0", pause);
    end
    @(negedge src_clk);
    btn_pause = 1'b0;
    repeat (20) @(posedge src_clk);
    @(negedge src_clk);
    btn_clr = 1'b0;
    wait_sig(2, 1'b0, 30, n);
    exp_q.push_back(2 * HALF_DIV);
    wait_sig(3, 1'b1, 40, n);
    exp = exp_q.pop_front();
    tests_run++;
    if (n != exp) begin
      tests_failed++;
      $display("FAIL clear_realign: first_tick_after=%0d required=%0d", n, exp);
    end
  endtask

  task automatic test_coincident;
    int n, exp;
    logic prev_pause, hit;
    @(negedge src_clk);
    btn_pause = 1'b1;
    btn_clr   = 1'b1;
    exp_q.push_back(int'(!pause));
    prev_pause = pause;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge src_clk); #1;
      if (clr_pulse === 1'b1) begin
        hit = 1'b1;
        break;
      end
      prev_pause = pause;
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (hit !== 1'b1 || int'(pause) != exp) begin
      tests_failed++;
      $display("FAIL coincident_toggle: clr_pulse_seen=%b pause=%b required 1 %0d", hit, pause, exp);
    end
    tests_run++;
    if (int'(prev_pause) == exp) begin
      tests_failed++;
      $display("FAIL coincident_same_cycle: pause_before=%b required=%0d", prev_pause, int'(!exp[0]));
    end
    @(negedge src_clk);
    btn_pause = 1'b0;
    btn_clr   = 1'b0;
    repeat (25) @(posedge src_clk);
    @(negedge src_clk);
    btn_clr = 1'b1;
    repeat (7) @(posedge src_clk);
    @(negedge src_clk);
    src_rst = 1'b0;
    repeat (2) @(posedge src_clk);
    #1;
    tests_run++;
    if (pause !== 1'b0 || clr_hold !== 1'b0 || clr_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL midqual_reset: pause=%b clr_hold=%b clr_pulse=%b required 0 0 0", pause, clr_hold, clr_pulse);
    end
    @(negedge src_clk);
    src_rst = 1'b1;
    wait_sig(1, 1'b1, 30, n);
    tests_run++;
    if (n < 11 || n > 14) begin
      tests_failed++;
      $display("FAIL requalify_after_reset: cycles=%0d required 11..14", n);
    end
    @(negedge src_clk);
    btn_clr = 1'b0;
    repeat (20) @(posedge src_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_bounce();
    test_run_rate();
    test_pause_clear();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
Input-conditioning and timebase stage that sits directly upstream of the stopwatch counter core. It synchronizes and debounces the pause and clear buttons, holds the pause state, and registers the mode switches. It also produces single-cycle count enables on the system clock, replacing the divided-clock muxing in the counter. All outputs are in the src_clk domain; the counter core consumes count_tick, clr_pulse, pause, mode and adj_min.

Parameters:
SAMPLE_DIV, 250000, src_clk cycles per debounce sample tick (2.5 ms at 100 MHz); legal range >=2
DEB_COUNT, 4, consecutive differing samples required to accept a new button level; legal range >=2
HALF_DIV, 50000000, src_clk cycles per half-second tick; legal range >=2

Ports:
src_clk  input  1  system clock
src_rst  input  1  asynchronous, active-low reset
btn_pause  input  1  raw pause/resume button, asynchronous
btn_clr  input  1  raw clear button, asynchronous
sw  input  3  raw switches: sw[1:0] mode, sw[2] adjust-select (1 = minutes)
pause  output  1  current pause state
clr_pulse  output  1  one-cycle pulse on accepted clear press
clr_hold  output  1  debounced clear level
count_tick  output  1  one-cycle counter enable
mode  output  2  registered sw[1:0]: 00 run, 01 adjust, 1x countdown
adj_min  output  1  registered sw[2]
blink  output  1  adjust-mode blink phase for the display stage

Behaviour:
- Reset (src_rst=0, asynchronous): all synchronizers, debounce counters and stable levels go to 0. All dividers go to 0. Outputs: pause=0, clr_pulse=0, clr_hold=0, count_tick=0, mode=00, adj_min=0, blink=0.
- Synchronizers: 2-flop synchronizer on btn_pause, btn_clr and sw[2:0]. mode and adj_min equal the synchronizer outputs, giving 2-cycle latency.
- Sample divider: counter runs 0..SAMPLE_DIV-1 and wraps. sample_tick=1 in the cycle when the count equals SAMPLE_DIV-1.
- Debouncer, one per button, updated only on sample_tick:
  - If the synced input differs from the stable level, increment the per-button counter.
  - When that counter reaches DEB_COUNT-1 on a differing sample, the stable level takes the input value and the counter clears.
  - If the synced input equals the stable level, the counter clears, so bounce restarts qualification.
- Edge detect: a 0->1 transition of a stable level produces a 1-cycle press pulse in the same cycle the stable level changes. Releases generate nothing.
- clr_hold = stable clear level. clr_pulse = clear press pulse.
- pause toggles on each pause press pulse. Clear does not change pause. If pause and clear presses coincide, pause toggles and clr_pulse still fires.
- Half-second divider: counter runs 0..HALF_DIV-1. half_tick is asserted when the count equals HALF_DIV-1. The phase bit toggles on each half_tick, and blink = phase.
- count_tick:
  - Asserted for 1 cycle on half_tick when mode==01.
  - Otherwise asserted on half_tick only when phase==1 before toggling, giving a 1 Hz rate.
- Suppression: count_tick is forced to 0 while pause=1 or clr_hold=1. The dividers keep running while paused.
- Clear realignment: while clr_hold=1, the half divider and phase are held at 0. After release, the first count_tick comes exactly 2*HALF_DIV cycles later (HALF_DIV in adjust mode).
- Mode change mid-count: dividers are not reset, and the new rate applies from the next half_tick.
- Reset asserted mid-operation clears everything immediately. After deassertion, button presses held through reset are accepted only after full debounce qualification.

Test Plan:
Test parameters: SAMPLE_DIV=4, DEB_COUNT=3, HALF_DIV=10.
1. Reset: pulse src_rst low with random inputs -> all outputs 0 during reset and on the first cycle after release.
2. Debounce accept: hold btn_pause=1 -> exactly one pause rise 0->1, 3 sample ticks (+2 sync cycles) after assertion. Release and press again -> pause returns to 0.
3. Bounce reject: toggle btn_pause every 4 cycles for 40 cycles, then hold 0 -> pause stays 0 and no edge is produced.
4. Run rate: mode=00, no buttons -> count_tick pulses exactly every 20 cycles. Switch to mode=01 -> pulses every 10 cycles from the next half_tick, and blink toggles every 10 cycles.
5. Pause and clear: set pause=1 -> count_tick stays 0 for 100 cycles. Press btn_clr -> clr_pulse is high for exactly 1 cycle and pause stays 1. Unpause and release clear -> first count_tick exactly 20 cycles after clr_hold falls.
6. Coincident presses: press both buttons in the same cycle -> pause toggles and clr_pulse fires in the same cycle. Assert src_rst mid-qualification -> no pulse is produced afterwards until a full requalification.
